// File: rtl/pipe_stage_chain_if.sv
// Handshake and observation bundle for pipe_stage_chain.
// master = producer/consumer side, slave = the pipeline itself.
interface pipe_stage_chain_if #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int IDX_W   = 2,
    parameter int COUNT_W = 16
);
    logic                   in_valid;
    logic [WIDTH-1:0]       in_data;
    logic                   in_ready;
    logic [DEPTH-1:0]       stall_vec;
    logic                   flush;
    logic [IDX_W-1:0]       flush_upto;
    logic                   out_ready;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic [DEPTH-1:0]       stage_valid;
    logic [DEPTH*WIDTH-1:0] stage_data;
    logic [COUNT_W-1:0]     bubble_count;

    modport master (
        output in_valid, in_data, stall_vec, flush, flush_upto, out_ready,
        input  in_ready, out_valid, out_data, stage_valid, stage_data, bubble_count
    );

    modport slave (
        input  in_valid, in_data, stall_vec, flush, flush_upto, out_ready,
        output in_ready, out_valid, out_data, stage_valid, stage_data, bubble_count
    );
endinterface

// File: rtl/pipe_stage_chain.sv
// Pipeline register chain with per-stage valid, stall holds, bubble collapse,
// younger-stage flush and a saturating count of empty output cycles.
module pipe_stage_chain #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int IDX_W   = 2,
    parameter int COUNT_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    pipe_stage_chain_if.slave bus
);

    logic [DEPTH-1:0]            r_valid;
    logic [DEPTH-1:0][WIDTH-1:0] r_data;
    logic [COUNT_W-1:0]          r_bubble;

    logic [DEPTH-1:0] w_seff;
    logic [DEPTH-1:0] w_hold;
    logic [DEPTH-1:0] w_kill;
    logic             w_in_ready;
    logic             w_load;

    // A hold only propagates upstream through valid stages, so bubbles get squeezed out.
    always_comb begin
        logic carry;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_seff = bus.stall_vec & r_valid;
        w_seff[DEPTH-1] = w_seff[DEPTH-1] | (r_valid[DEPTH-1] & ~bus.out_ready);
        w_hold = '0;
        w_kill = '0;
        // NOTE: 'carry' is a blocking temporary, read after write within the same pass.
        carry = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            carry     = w_seff[k] | (r_valid[k] & carry);
            w_hold[k] = carry;
            w_kill[k] = bus.flush & (IDX_W'(k) <= bus.flush_upto);
        end
    end

    assign w_in_ready = ~w_hold[0] & ~bus.flush & ~reset;
    assign w_load     = bus.in_valid & w_in_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid  <= '0;
            // NOTE: payload registers are reset as well so no X ever reaches stage_data.
            r_data   <= '0;
            r_bubble <= '0;
        end else begin
            // NOTE: all state updates use non-blocking assignment so stages read pre-edge values.
            if (w_kill[0]) begin
                r_valid[0] <= 1'b0;
            end else if (!w_hold[0]) begin
                r_valid[0] <= w_load;
                if (w_load) r_data[0] <= bus.in_data;
            end

            for (int k = 1; k < DEPTH; k++) begin
                if (w_kill[k]) begin
                    r_valid[k] <= 1'b0;
                end else if (w_hold[k]) begin
                    r_valid[k] <= r_valid[k];
                end else if (w_hold[k-1]) begin
                    r_valid[k] <= 1'b0;
                end else begin
                    r_valid[k] <= r_valid[k-1];
                    r_data[k]  <= r_data[k-1];
                end
            end

            if (!r_valid[DEPTH-1] && (r_bubble != '1)) r_bubble <= r_bubble + 1'b1;
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = r_valid[DEPTH-1];
    assign bus.out_data     = r_data[DEPTH-1];
    assign bus.stage_valid  = r_valid;
    assign bus.stage_data   = r_data;
    assign bus.bubble_count = r_bubble;

endmodule
